// File: rtl/mst_fsm_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mst_fsm_if
// Description : Request/ack bus between the mst_fsm initiator and a register
//               slave. The master drives the request side; the slave returns
//               ack, read data and error.
// Revision    : 1.0
// ============================================================================
interface mst_fsm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  // Master -> slave
  logic                  soft_rst;
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Slave -> master
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;

  modport master (
    output soft_rst, req_vld, wr_en, rd_en, addr, wr_data,
    input  ack_vld, rd_data, err
  );

  modport slave (
    input  soft_rst, req_vld, wr_en, rd_en, addr, wr_data,
    output ack_vld, rd_data, err
  );

endinterface
`default_nettype wire

// File: rtl/mst_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mst_fsm
// Description : Initiator for the register-slave request/ack bus. Takes one
//               upstream command, issues a single-cycle request, waits for the
//               ack (bounded by a timeout that soft-resets a hung slave) and
//               returns read data / error status upstream.
// Revision    : 1.0
// ============================================================================
module mst_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  soft_rst_i,
  // upstream command
  input  wire logic                  cmd_vld_i,
  output      logic                  cmd_rdy_o,
  input  wire logic                  cmd_wr_i,
  input  wire logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  wire logic [DATA_WIDTH-1:0] cmd_wdata_i,
  // upstream response
  output      logic                  rsp_vld_o,
  input  wire logic                  rsp_rdy_i,
  output      logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output      logic                  rsp_err_o,
  output      logic                  rsp_timeout_o,
  // register-slave bus
  mst_fsm_if.master                  bus
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; keep at least one bit so the
  // register exists even when the timeout is disabled.
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMR_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LAST_INT);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_TOUT = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_vld_q, req_vld_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tout_q, tout_d;

  // Next-state and next-register computation; soft_rst overrides everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wr_en_d = wr_en_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tout_d  = tout_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_vld_i) begin
          state_d = S_REQ;
          wr_en_d = cmd_wr_i;
          rd_en_d = ~cmd_wr_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
        timer_d = '0;
      end

      S_WAIT: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus.ack_vld) begin
          state_d = S_RESP;
          err_d   = bus.err;
          rdata_d = rd_en_q ? bus.rd_data : '0;
          tout_d  = 1'b0;
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          state_d = S_TOUT;
        end else if (TMO_EN) begin
          // Bounded by TMR_LAST above, so the timer never wraps.
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_TOUT: begin
        state_d = S_RESP;
        err_d   = 1'b1;
        tout_d  = 1'b1;
        rdata_d = '0;
      end

      S_RESP: begin
        if (rsp_rdy_i) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
          tout_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: drop the transaction and any pending response.
    if (soft_rst_i) begin
      state_d = S_IDLE;
      timer_d = '0;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      rdata_d = '0;
      err_d   = 1'b0;
      tout_d  = 1'b0;
    end

    // Handshake flags are registered decodes of the next state so that every
    // upstream/bus output except if_soft_rst comes straight from a flop.
    req_vld_d = (state_d == S_REQ);
    rsp_vld_d = (state_d == S_RESP);
    cmd_rdy_d = (state_d == S_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_vld_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      cmd_rdy_q <= 1'b1;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_vld_q <= req_vld_d;
      rsp_vld_q <= rsp_vld_d;
      cmd_rdy_q <= cmd_rdy_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
    end
  end

  // The slave soft reset follows the upstream abort immediately and is also
  // pulsed for the single timeout-recovery cycle.
  assign bus.soft_rst = soft_rst_i | (state_q == S_TOUT);
  assign bus.req_vld  = req_vld_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.addr     = addr_q;
  assign bus.wr_data  = wdata_q;

  assign cmd_rdy_o     = cmd_rdy_q;
  assign rsp_vld_o     = rsp_vld_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_mst_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mst_fsm
// Description : Self-checking bench for mst_fsm: directed scenarios plus a
//               randomized stream checked against a cycle-timing model.
// Revision    : 1.0
// ============================================================================
module tb_mst_fsm;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_rst = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_rdy = 1'b0;
  logic          cmd_rdy, rsp_vld, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mst_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mst_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_i(soft_rst),
    .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Observations of one transaction; cycle numbers count from the accept edge
  // (cycle 1 is the first cycle after the command is accepted).
  typedef struct {
    int            req_cnt, req_cyc;
    logic          req_wr, req_rd;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    bit            bus_stable;
    int            srst_cnt, srst_cyc;
    int            rsp_cyc, vld_cnt;
    logic [DW-1:0] rdata;
    logic          err, tout;
    bit            rsp_stable;
    int            idle_cyc, acc_cyc;
    bit            rdy_in_hold;
    bit            hung;
  } obs_t;

  typedef struct {
    int            rsp_cyc, vld_cnt, srst_cnt, srst_cyc, idle_cyc;
    logic [DW-1:0] rdata;
    logic          err, tout;
  } exp_t;

  // Reference model: outcome and timing from the protocol rules alone.
  function automatic exp_t model(input bit wr, input int ack_at, input bit aerr,
                                 input logic [DW-1:0] ardata, input int soft_at,
                                 input int rdy_wait);
    exp_t e;
    bit aborted, acked;
    aborted = (soft_at >= 0) && (soft_at < TO) && (ack_at < 0 || soft_at <= ack_at);
    acked   = !aborted && (ack_at >= 0) && (ack_at < TO);
    if (aborted) begin
      e.rsp_cyc = -1; e.vld_cnt = 0; e.srst_cnt = 1; e.srst_cyc = 2 + soft_at;
      e.idle_cyc = 3 + soft_at; e.rdata = '0; e.err = 1'b0; e.tout = 1'b0;
    end else if (acked) begin
      e.rsp_cyc = 3 + ack_at; e.srst_cnt = 0; e.srst_cyc = -1;
      e.rdata = wr ? '0 : ardata; e.err = aerr; e.tout = 1'b0;
    end else begin
      e.rsp_cyc = 3 + TO; e.srst_cnt = 1; e.srst_cyc = 2 + TO;
      e.rdata = '0; e.err = 1'b1; e.tout = 1'b1;
    end
    if (!aborted) begin
      e.vld_cnt  = rdy_wait + 1;
      e.idle_cyc = e.rsp_cyc + rdy_wait + 1;
    end
    return e;
  endfunction

  // Drives one command plus slave behaviour and records what the DUT did.
  // ack_at/soft_at are S_WAIT-cycle indices (0 = first wait cycle), -1 = none.
  // With chain set, the next command (n*) is presented as soon as the
  // response appears and the task returns right after it is accepted.
  task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int ack_at, input bit aerr, input logic [DW-1:0] ardata,
                     input int soft_at, input int rdy_wait, input bit pre_acc,
                     input bit chain, input bit nwr, input logic [AW-1:0] naddr,
                     input logic [DW-1:0] nwdata, output obs_t o);
    int bus_end;
    bit seen_rsp, ended;
    o = '{default: 0};
    o.req_cyc = -1; o.srst_cyc = -1; o.rsp_cyc = -1; o.idle_cyc = -1; o.acc_cyc = -1;
    o.bus_stable = 1'b1; o.rsp_stable = 1'b1;
    bus_end = (ack_at >= 0 && ack_at < TO) ? 2 + ack_at : 1 + TO;
    if (soft_at >= 0 && 2 + soft_at < bus_end) bus_end = 2 + soft_at;
    seen_rsp = 1'b0;
    ended    = 1'b0;
    if (!pre_acc) begin
      @(negedge clk);
      cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    end
    for (int k = 1; k <= 40 && !ended; k++) begin
      @(negedge clk);
      cmd_vld = chain && seen_rsp;
      bus_if.ack_vld = (ack_at >= 0) && (k == 2 + ack_at);
      bus_if.err     = bus_if.ack_vld ? aerr : 1'($urandom);
      bus_if.rd_data = bus_if.ack_vld ? ardata : DW'($urandom);
      soft_rst       = (soft_at >= 0) && (k == 2 + soft_at);
      #1;
      if (bus_if.req_vld === 1'b1) begin
        o.req_cnt++;
        if (o.req_cyc < 0) begin
          o.req_cyc = k; o.req_wr = bus_if.wr_en; o.req_rd = bus_if.rd_en;
          o.req_addr = bus_if.addr; o.req_wdata = bus_if.wr_data;
        end
      end
      if (o.req_cyc >= 0 && k <= bus_end &&
          (bus_if.wr_en !== o.req_wr || bus_if.rd_en !== o.req_rd ||
           bus_if.addr !== o.req_addr || bus_if.wr_data !== o.req_wdata))
        o.bus_stable = 1'b0;
      if (bus_if.soft_rst === 1'b1) begin
        o.srst_cnt++;
        if (o.srst_cyc < 0) o.srst_cyc = k;
      end
      if (rsp_vld === 1'b1) begin
        o.vld_cnt++;
        if (!seen_rsp) begin
          seen_rsp = 1'b1; o.rsp_cyc = k;
          o.rdata = rsp_rdata; o.err = rsp_err; o.tout = rsp_timeout;
          if (chain) begin
            cmd_vld = 1'b1; cmd_wr = nwr; cmd_addr = naddr; cmd_wdata = nwdata;
          end
        end else if (rsp_rdata !== o.rdata || rsp_err !== o.err || rsp_timeout !== o.tout) begin
          o.rsp_stable = 1'b0;
        end
        if (cmd_rdy === 1'b1) o.rdy_in_hold = 1'b1;
      end
      if (rsp_vld !== 1'b1 && cmd_rdy === 1'b1 && o.idle_cyc < 0 && k > 1) o.idle_cyc = k;
      rsp_rdy = (rsp_vld === 1'b1) && (o.vld_cnt > rdy_wait);
      if (chain && cmd_vld && cmd_rdy === 1'b1) begin
        o.acc_cyc = k; ended = 1'b1;
      end else if (!chain && k > 2 + ack_at && k > 2 + soft_at && k > 1 &&
                   cmd_rdy === 1'b1 && rsp_vld !== 1'b1) begin
        ended = 1'b1;
      end
    end
    if (!ended) o.hung = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_rdy !== 1'b1) $display("FAIL rst_cmd_rdy: got %b want 1", cmd_rdy); else n_pass++;
    n_checks++;
    if ({rsp_vld, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0)
      $display("FAIL rst_rsp: got vld/err/tout %b%b%b rdata %h want 000 0", rsp_vld, rsp_err, rsp_timeout, rsp_rdata);
    else n_pass++;
    n_checks++;
    if ({bus_if.soft_rst, bus_if.req_vld, bus_if.wr_en, bus_if.rd_en} !== 4'b0000 ||
        bus_if.addr !== '0 || bus_if.wr_data !== '0)
      $display("FAIL rst_bus: got srst/req/wr/rd %b%b%b%b addr %h wdata %h want all 0",
               bus_if.soft_rst, bus_if.req_vld, bus_if.wr_en, bus_if.rd_en, bus_if.addr, bus_if.wr_data);
    else n_pass++;
    rst_n = 1'b1;
    // Asynchronous reset in the middle of a request cycle.
    @(negedge clk); cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'hABC; cmd_wdata = 32'h77;
    @(negedge clk); cmd_vld = 1'b0;
    #1;
    n_checks++; if (bus_if.req_vld !== 1'b1) $display("FAIL pre_arst_req: got %b want 1", bus_if.req_vld); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.req_vld !== 1'b0 || cmd_rdy !== 1'b1 || bus_if.wr_en !== 1'b0 || bus_if.addr !== '0)
      $display("FAIL arst_clear: got req %b rdy %b wr %b addr %h want 0 1 0 0",
               bus_if.req_vld, cmd_rdy, bus_if.wr_en, bus_if.addr);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    obs_t o;
    txn(1'b1, 32'h10, 32'hCAFE, 0, 1'b0, 32'h5555_AAAA, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.req_cnt !== 1 || o.req_cyc !== 1) $display("FAIL wr_req: got cnt %0d cyc %0d want 1 1", o.req_cnt, o.req_cyc); else n_pass++;
    n_checks++; if (o.req_wr !== 1'b1 || o.req_rd !== 1'b0) $display("FAIL wr_en: got wr %b rd %b want 1 0", o.req_wr, o.req_rd); else n_pass++;
    n_checks++; if (o.req_addr !== 32'h10 || o.req_wdata !== 32'hCAFE) $display("FAIL wr_bus: got %h %h want 10 cafe", o.req_addr, o.req_wdata); else n_pass++;
    n_checks++; if (o.rsp_cyc !== 3) $display("FAIL wr_rsp_cyc: got %0d want 3", o.rsp_cyc); else n_pass++;
    n_checks++; if (o.rdata !== '0 || o.err !== 1'b0 || o.tout !== 1'b0) $display("FAIL wr_rsp: got %h %b %b want 0 0 0", o.rdata, o.err, o.tout); else n_pass++;
  endtask

  task automatic test_read();
    obs_t o;
    txn(1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h1234, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.bus_stable !== 1'b1) $display("FAIL rd_bus_stable: got %b want 1", o.bus_stable); else n_pass++;
    n_checks++; if (o.req_rd !== 1'b1 || o.req_addr !== 32'h20) $display("FAIL rd_req: got rd %b addr %h want 1 20", o.req_rd, o.req_addr); else n_pass++;
    n_checks++; if (o.rsp_cyc !== 6) $display("FAIL rd_rsp_cyc: got %0d want 6", o.rsp_cyc); else n_pass++;
    n_checks++; if (o.rdata !== 32'h1234 || o.err !== 1'b0 || o.tout !== 1'b0) $display("FAIL rd_rsp: got %h %b %b want 1234 0 0", o.rdata, o.err, o.tout); else n_pass++;
  endtask

  task automatic test_error();
    obs_t o;
    txn(1'b0, 32'hFFF0, 32'h0, 1, 1'b1, 32'hDEAD, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.rdata !== 32'hDEAD || o.err !== 1'b1 || o.tout !== 1'b0) $display("FAIL err_rsp: got %h %b %b want dead 1 0", o.rdata, o.err, o.tout); else n_pass++;
    n_checks++; if (o.srst_cnt !== 0) $display("FAIL err_srst: got %0d want 0", o.srst_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    txn(1'b0, 32'h40, 32'h0, -1, 1'b0, 32'h0, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.srst_cnt !== 1 || o.srst_cyc !== 6) $display("FAIL to_srst: got cnt %0d cyc %0d want 1 6", o.srst_cnt, o.srst_cyc); else n_pass++;
    n_checks++; if (o.rsp_cyc !== 7) $display("FAIL to_rsp_cyc: got %0d want 7", o.rsp_cyc); else n_pass++;
    n_checks++; if (o.rdata !== '0 || o.err !== 1'b1 || o.tout !== 1'b1) $display("FAIL to_rsp: got %h %b %b want 0 1 1", o.rdata, o.err, o.tout); else n_pass++;
    // Ack in the last allowed wait cycle beats the timeout.
    txn(1'b0, 32'h44, 32'h0, TO - 1, 1'b0, 32'h9876, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.srst_cnt !== 0 || o.tout !== 1'b0) $display("FAIL to_last_ack: got srst %0d tout %b want 0 0", o.srst_cnt, o.tout); else n_pass++;
    n_checks++; if (o.rsp_cyc !== 6 || o.rdata !== 32'h9876) $display("FAIL to_last_rsp: got cyc %0d rdata %h want 6 9876", o.rsp_cyc, o.rdata); else n_pass++;
    // Ack one cycle too late lands in S_TOUT and is ignored.
    txn(1'b0, 32'h48, 32'h0, TO, 1'b0, 32'h4321, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.tout !== 1'b1 || o.rdata !== '0 || o.rsp_cyc !== 7) $display("FAIL to_late_ack: got tout %b rdata %h cyc %0d want 1 0 7", o.tout, o.rdata, o.rsp_cyc); else n_pass++;
  endtask

  task automatic test_soft_abort();
    obs_t o;
    txn(1'b0, 32'h50, 32'h0, 3, 1'b0, 32'hBEEF, 1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.srst_cnt !== 1 || o.srst_cyc !== 3) $display("FAIL ab_srst: got cnt %0d cyc %0d want 1 3", o.srst_cnt, o.srst_cyc); else n_pass++;
    n_checks++; if (o.vld_cnt !== 0) $display("FAIL ab_no_rsp: got %0d rsp_vld cycles want 0", o.vld_cnt); else n_pass++;
    n_checks++; if (o.idle_cyc !== 4) $display("FAIL ab_idle: got %0d want 4", o.idle_cyc); else n_pass++;
    txn(1'b0, 32'h54, 32'h0, 0, 1'b0, 32'h600D, -1, 0, 1'b0, 1'b0, 1'b0, '0, '0, o);
    n_checks++; if (o.rsp_cyc !== 3 || o.rdata !== 32'h600D || o.err !== 1'b0) $display("FAIL ab_next: got cyc %0d rdata %h err %b want 3 600d 0", o.rsp_cyc, o.rdata, o.err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    txn(1'b0, 32'h60, 32'h0, 0, 1'b0, 32'hA5A5, -1, 5, 1'b0, 1'b1, 1'b1, 32'h64, 32'h1357, o);
    n_checks++; if (o.hung !== 1'b0) $display("FAIL b2b_hung: got %b want 0", o.hung); else n_pass++;
    n_checks++; if (o.vld_cnt !== 6 || o.rsp_stable !== 1'b1) $display("FAIL b2b_hold: got vld %0d stable %b want 6 1", o.vld_cnt, o.rsp_stable); else n_pass++;
    n_checks++; if (o.rdy_in_hold !== 1'b0) $display("FAIL b2b_cmd_rdy: got %b want 0", o.rdy_in_hold); else n_pass++;
    n_checks++; if (o.acc_cyc !== 9) $display("FAIL b2b_accept: got %0d want 9", o.acc_cyc); else n_pass++;
    txn(1'b1, 32'h64, 32'h1357, 0, 1'b0, 32'h0, -1, 0, 1'b1, 1'b0, 1'b0, '0, '0, o);
    n_checks++;
    if (o.req_cyc !== 1 || o.req_wr !== 1'b1 || o.req_addr !== 32'h64 || o.req_wdata !== 32'h1357)
      $display("FAIL b2b_second_req: got cyc %0d wr %b addr %h wdata %h want 1 1 64 1357", o.req_cyc, o.req_wr, o.req_addr, o.req_wdata);
    else n_pass++;
    n_checks++; if (o.rsp_cyc !== 3 || o.rdata !== '0) $display("FAIL b2b_second_rsp: got cyc %0d rdata %h want 3 0", o.rsp_cyc, o.rdata); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit wr, aerr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, ardata;
    int ack_at, soft_at, rdy_wait;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); aerr = 1'($urandom);
      addr = $urandom; wdata = $urandom; ardata = $urandom;
      ack_at = int'($urandom_range(0, 6)) - 1;
      rdy_wait = int'($urandom_range(0, 3));
      soft_at = -1;
      if ($urandom_range(0, 4) == 0) begin
        soft_at = int'($urandom_range(0, TO - 1));
        if (ack_at >= 0 && ack_at < soft_at) ack_at = soft_at + int'($urandom_range(0, 2));
      end
      txn(wr, addr, wdata, ack_at, aerr, ardata, soft_at, rdy_wait, 1'b0, 1'b0, 1'b0, '0, '0, o);
      e = model(wr, ack_at, aerr, ardata, soft_at, rdy_wait);
      n_checks++; if (o.hung !== 1'b0) $display("FAIL rnd%0d_hung: got %b want 0", i, o.hung); else n_pass++;
      n_checks++;
      if (o.req_cnt !== 1 || o.req_cyc !== 1 || o.req_wr !== wr || o.req_rd !== !wr ||
          o.req_addr !== addr || o.req_wdata !== wdata || o.bus_stable !== 1'b1)
        $display("FAIL rnd%0d_req: got cnt %0d cyc %0d wr %b rd %b addr %h wd %h stable %b want 1 1 %b %b %h %h 1",
                 i, o.req_cnt, o.req_cyc, o.req_wr, o.req_rd, o.req_addr, o.req_wdata, o.bus_stable, wr, !wr, addr, wdata);
      else n_pass++;
      n_checks++;
      if (o.rsp_cyc !== e.rsp_cyc || o.vld_cnt !== e.vld_cnt || o.idle_cyc !== e.idle_cyc)
        $display("FAIL rnd%0d_timing: got rsp %0d vld %0d idle %0d want %0d %0d %0d",
                 i, o.rsp_cyc, o.vld_cnt, o.idle_cyc, e.rsp_cyc, e.vld_cnt, e.idle_cyc);
      else n_pass++;
      n_checks++;
      if (o.srst_cnt !== e.srst_cnt || o.srst_cyc !== e.srst_cyc)
        $display("FAIL rnd%0d_srst: got cnt %0d cyc %0d want %0d %0d", i, o.srst_cnt, o.srst_cyc, e.srst_cnt, e.srst_cyc);
      else n_pass++;
      if (e.rsp_cyc >= 0) begin
        n_checks++;
        if (o.rdata !== e.rdata || o.err !== e.err || o.tout !== e.tout || o.rsp_stable !== 1'b1)
          $display("FAIL rnd%0d_rsp: got %h %b %b stable %b want %h %b %b 1",
                   i, o.rdata, o.err, o.tout, o.rsp_stable, e.rdata, e.err, e.tout);
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus_if.ack_vld = 1'b0;
    bus_if.rd_data = '0;
    bus_if.err     = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_soft_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
